// File: rtl/eight_port_rr_arbiter.sv
// rtl/eight_port_rr_arbiter.sv - packet-aware 8-port round-robin arbiter driving an 8:1 data mux
module EightInputMux #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_data [7:0],
    input  logic [2:0]       i_sel,
    output logic [WIDTH-1:0] o_data
);
    assign o_data = i_data[i_sel];
endmodule

module eight_port_rr_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_in_valid,
    input  logic [7:0]       i_in_last,
    input  logic [WIDTH-1:0] i_in_data [7:0],
    output logic [7:0]       o_in_ready,
    output logic [2:0]       o_sel,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    output logic [2:0]       o_out_port,
    input  logic             i_out_ready
);
    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_rr_ptr;
    logic [2:0]       w_rr_ptr_next;
    logic [2:0]       r_lock_port;
    logic [2:0]       w_lock_port_next;
    logic [2:0]       w_rr_pick;
    logic [2:0]       w_sel;
    logic             w_load_en;
    logic             w_accept;
    logic             w_acc_last;
    logic [WIDTH-1:0] w_mux_data;

    // First valid port at or above ptr, wrapping; ptr itself when nobody is valid.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr);
        logic [2:0] idx;
        rr_pick = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (valid[idx]) rr_pick = idx;
        end
    endfunction

    assign w_rr_pick  = rr_pick(i_in_valid, r_rr_ptr);
    assign w_sel      = (r_state == ST_LOCKED) ? r_lock_port : w_rr_pick;
    assign w_load_en  = !o_out_valid || i_out_ready;
    assign o_in_ready = (!i_rst && w_load_en && i_in_valid[w_sel]) ? (8'd1 << w_sel) : 8'd0;
    assign o_sel      = w_sel;
    assign w_accept   = |o_in_ready;
    assign w_acc_last = i_in_last[w_sel];

    EightInputMux #(.WIDTH(WIDTH)) u_mux (
        .i_data (i_in_data),
        .i_sel  (w_sel),
        .o_data (w_mux_data)
    );

    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_lock_port_next = r_lock_port;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_acc_last) begin
                        w_rr_ptr_next = w_sel + 3'd1;
                    end else begin
                        w_state_next     = ST_LOCKED;
                        w_lock_port_next = w_sel;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_acc_last) begin
                    w_state_next  = ST_IDLE;
                    w_rr_ptr_next = r_lock_port + 3'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 3'd0;
            r_lock_port <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_lock_port <= w_lock_port_next;
        end
    end

    // Single-entry output stage; a new accept overwrites a beat being drained this cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_out_last  <= 1'b0;
            o_out_port  <= 3'd0;
        end else if (w_accept) begin
            o_out_valid <= 1'b1;
            o_out_data  <= w_mux_data;
            o_out_last  <= w_acc_last;
            o_out_port  <= w_sel;
        end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end
endmodule
